// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch state encodings
package cpu_pkg;

    localparam logic [2:0]  OPC_TWO_WORD = 3'b110;
    localparam logic [15:0] NOP_INSTR    = 16'h0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        IMM  = 2'd2,
        INT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC/fetch FSM with two-word instructions, flush, stall and interrupt injection
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR_ADDR = 16'h0000,
    parameter logic [15:0] INT_VECTOR_ADDR   = 16'h0001
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [15:0] i_branch_target,
    input  logic        i_interrupt,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_imm_value,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_next,
    output logic        o_valid,
    output logic        o_interrupt
);

    fetch_state_t r_state, w_state_next;
    logic [15:0]  r_pc, w_pc_next_val;
    logic [15:0]  r_hold, w_hold_next;
    logic [15:0]  r_hold_pc, w_hold_pc_next;
    logic         r_pending, w_pending_next;
    logic [15:0]  r_instr, w_instr_next;
    logic [15:0]  r_imm, w_imm_next;
    logic [15:0]  r_opc, w_opc_next;
    logic [15:0]  r_opc_next, w_opc_next_next;
    logic         r_valid, w_valid_next;
    logic         r_int, w_int_next;

    logic [15:0]  w_pc_inc;
    logic         w_two_word;

    assign w_pc_inc   = r_pc + 16'd1;
    assign w_two_word = (i_imem_data[15:13] == OPC_TWO_WORD);

    always_comb begin
        case (r_state)
            BOOT:    o_imem_addr = RESET_VECTOR_ADDR;
            INT:     o_imem_addr = INT_VECTOR_ADDR;
            default: o_imem_addr = r_pc;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next_val   = r_pc;
        w_hold_next     = r_hold;
        w_hold_pc_next  = r_hold_pc;
        w_pending_next  = r_pending | i_interrupt;
        w_instr_next    = r_instr;
        w_imm_next      = r_imm;
        w_opc_next      = r_opc;
        w_opc_next_next = r_opc_next;
        w_valid_next    = r_valid;
        w_int_next      = r_int;

        // The boot vector load cannot be redirected; a flush there is dropped.
        if (i_flush && r_state != BOOT) begin
            w_pc_next_val = i_branch_target;
            w_valid_next  = 1'b0;
            w_int_next    = 1'b0;
            w_state_next  = RUN;
        end else if (!i_stall) begin
            case (r_state)
                BOOT: begin
                    w_pc_next_val = i_imem_data;
                    w_valid_next  = 1'b0;
                    w_state_next  = RUN;
                end
                RUN: begin
                    if (r_pending) begin
                        w_valid_next = 1'b0;
                        w_int_next   = 1'b0;
                        w_state_next = INT;
                    end else if (w_two_word) begin
                        w_hold_next    = i_imem_data;
                        w_hold_pc_next = r_pc;
                        w_pc_next_val  = w_pc_inc;
                        w_valid_next   = 1'b0;
                        w_int_next     = 1'b0;
                        w_state_next   = IMM;
                    end else begin
                        w_instr_next    = i_imem_data;
                        w_opc_next      = r_pc;
                        w_opc_next_next = w_pc_inc;
                        w_valid_next    = 1'b1;
                        w_int_next      = 1'b0;
                        w_pc_next_val   = w_pc_inc;
                    end
                end
                IMM: begin
                    w_imm_next      = i_imem_data;
                    w_instr_next    = r_hold;
                    w_opc_next      = r_hold_pc;
                    w_opc_next_next = w_pc_inc;
                    w_valid_next    = 1'b1;
                    w_int_next      = 1'b0;
                    w_pc_next_val   = w_pc_inc;
                    w_state_next    = RUN;
                end
                INT: begin
                    w_instr_next    = NOP_INSTR;
                    w_opc_next      = r_pc;
                    w_opc_next_next = r_pc;
                    w_valid_next    = 1'b1;
                    w_int_next      = 1'b1;
                    w_pc_next_val   = i_imem_data;
                    w_pending_next  = i_interrupt;
                    w_state_next    = RUN;
                end
                default: w_state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= BOOT;
            r_pc       <= 16'h0000;
            r_hold     <= 16'h0000;
            r_hold_pc  <= 16'h0000;
            r_pending  <= 1'b0;
            r_instr    <= 16'h0000;
            r_imm      <= 16'h0000;
            r_opc      <= 16'h0000;
            r_opc_next <= 16'h0000;
            r_valid    <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next_val;
            r_hold     <= w_hold_next;
            r_hold_pc  <= w_hold_pc_next;
            r_pending  <= w_pending_next;
            r_instr    <= w_instr_next;
            r_imm      <= w_imm_next;
            r_opc      <= w_opc_next;
            r_opc_next <= w_opc_next_next;
            r_valid    <= w_valid_next;
            r_int      <= w_int_next;
        end
    end

    assign o_instr     = r_instr;
    assign o_imm_value = r_imm;
    assign o_pc        = r_opc;
    assign o_pc_next   = r_opc_next;
    assign o_valid     = r_valid;
    assign o_interrupt = r_int;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, intr;
    logic [15:0] target;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] instr, imm_value, pc, pc_next;
    logic        valid, interrupt;

    logic [15:0] mem [0:65535];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_branch_target (target),
        .i_interrupt     (intr),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .o_instr         (instr),
        .o_imm_value     (imm_value),
        .o_pc            (pc),
        .o_pc_next       (pc_next),
        .o_valid         (valid),
        .o_interrupt     (interrupt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] ins,
                             input logic [15:0] p, input logic [15:0] pn, input logic [15:0] addr);
        check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check_eq({tag, ".instr"}, {16'd0, instr}, {16'd0, ins});
        check_eq({tag, ".pc"}, {16'd0, pc}, {16'd0, p});
        check_eq({tag, ".pc_next"}, {16'd0, pc_next}, {16'd0, pn});
        check_eq({tag, ".addr"}, {16'd0, imem_addr}, {16'd0, addr});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h0010;
        mem[16'h0001] = 16'h0100;
        mem[16'h0010] = 16'h1111;
        mem[16'h0011] = 16'h2222;
        mem[16'h0012] = 16'h3333;
        mem[16'h0013] = 16'h4444;
        mem[16'h0014] = 16'hC000;
        mem[16'h0015] = 16'hBEEF;
        mem[16'h0100] = 16'h2AAA;
        mem[16'h0101] = 16'hC123;
        mem[16'h0102] = 16'h7777;
        mem[16'h0040] = 16'h1234;
        mem[16'h0041] = 16'h0042;
        mem[16'hFFFF] = 16'h3ABC;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; intr = 1'b0; target = 16'h0000;
        step(); step();
        check_out("reset", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check_eq("reset.int", {31'd0, interrupt}, 32'd0);
        check_eq("reset.imm", {16'd0, imm_value}, 32'd0);

        reset = 1'b0;
        step();
        check_out("boot", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0010);

        step();
        check_out("w16", 1'b1, 16'h1111, 16'h0010, 16'h0011, 16'h0011);
        step();
        check_out("w17", 1'b1, 16'h2222, 16'h0011, 16'h0012, 16'h0012);
        step();
        check_out("w18", 1'b1, 16'h3333, 16'h0012, 16'h0013, 16'h0013);
        step();
        check_out("w19", 1'b1, 16'h4444, 16'h0013, 16'h0014, 16'h0014);

        step();
        check_eq("tw.bubble", {31'd0, valid}, 32'd0);
        check_eq("tw.addr", {16'd0, imem_addr}, 32'h0015);

        intr = 1'b1;
        step();
        intr = 1'b0;
        check_out("tw", 1'b1, 16'hC000, 16'h0014, 16'h0016, 16'h0016);
        check_eq("tw.imm", {16'd0, imm_value}, 32'h0000BEEF);
        check_eq("tw.int", {31'd0, interrupt}, 32'd0);

        step();
        check_eq("irq.detect.valid", {31'd0, valid}, 32'd0);
        check_eq("irq.detect.addr", {16'd0, imem_addr}, 32'h0001);
        step();
        check_out("irq", 1'b1, 16'h0000, 16'h0016, 16'h0016, 16'h0100);
        check_eq("irq.int", {31'd0, interrupt}, 32'd1);

        step();
        check_out("handler", 1'b1, 16'h2AAA, 16'h0100, 16'h0101, 16'h0101);
        check_eq("handler.int", {31'd0, interrupt}, 32'd0);

        step();
        check_eq("tw2.bubble", {31'd0, valid}, 32'd0);
        flush = 1'b1; target = 16'h0040;
        step();
        flush = 1'b0;
        check_eq("flush.valid", {31'd0, valid}, 32'd0);
        check_eq("flush.addr", {16'd0, imem_addr}, 32'h0040);
        check_eq("flush.imm", {16'd0, imm_value}, 32'h0000BEEF);

        step();
        check_out("tgt", 1'b1, 16'h1234, 16'h0040, 16'h0041, 16'h0041);
        check_eq("tgt.imm", {16'd0, imm_value}, 32'h0000BEEF);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 1'b1, 16'h1234, 16'h0040, 16'h0041, 16'h0041);
        end
        stall = 1'b0;
        step();
        check_out("post_stall", 1'b1, 16'h0042, 16'h0041, 16'h0042, 16'h0042);

        flush = 1'b1; target = 16'hFFFF;
        step();
        flush = 1'b0;
        check_eq("wrapflush.valid", {31'd0, valid}, 32'd0);
        check_eq("wrapflush.addr", {16'd0, imem_addr}, 32'h0000FFFF);
        step();
        check_out("wrap", 1'b1, 16'h3ABC, 16'hFFFF, 16'h0000, 16'h0000);

        flush = 1'b1; target = 16'h0014;
        step();
        flush = 1'b0;
        step();
        check_eq("rst_imm.bubble", {31'd0, valid}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("rst_imm", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check_eq("rst_imm.imm", {16'd0, imm_value}, 32'd0);
        step();
        check_eq("reboot.addr", {16'd0, imem_addr}, 32'h0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

First pipeline stage: owns the program counter, reads 16-bit instruction words from instruction memory and presents one complete instruction per valid cycle to the IF/ID boundary, feeding the decode stage. It handles:
- boot-time PC load from a memory vector;
- two-word instructions, whose second word is a 16-bit immediate;
- branch redirects, with flush;
- stalls;
- injection of pending interrupts at instruction boundaries.

## Interface
- `RESET_VECTOR_ADDR`, default `16'h0000`: memory word holding the boot PC.
- `INT_VECTOR_ADDR`, default `16'h0001`: memory word holding the interrupt handler PC.
- `i_clk`, input, 1: clock, rising edge.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_stall`, input, 1: hold PC, state and all outputs.
- `i_flush`, input, 1: branch taken; redirect the PC and squash the word being fetched.
- `i_branch_target`, input, 16: new PC when `i_flush` is asserted.
- `i_interrupt`, input, 1: interrupt request; a one-cycle pulse is enough.
- `o_imem_addr`, output, 16: instruction memory word address. Combinational.
- `i_imem_data`, input, 16: instruction memory read data. Asynchronous read, valid in the same cycle.
- `o_instr`, output, 16: instruction word (first word) for decode.
- `o_imm_value`, output, 16: second word of a two-word instruction. Otherwise it holds its last value.
- `o_pc`, output, 16: address of `o_instr`.
- `o_pc_next`, output, 16: address following the instruction, used as the return address for CALL and interrupts.
- `o_valid`, output, 1: IF/ID contents are a real instruction.
- `o_interrupt`, output, 1: IF/ID carries an injected interrupt. Drives decode's `i_interrupt`.

## Operation
- **States:** `BOOT`, `RUN`, `IMM`, `INT`.
- **Two-word instructions:** an instruction is two-word iff `i_imem_data[15:13] == OPC_TWO_WORD`.
- **Priority per cycle:** `i_reset` > `i_flush` > `i_stall` > normal operation.

Reset:
- All registered outputs become 0. PC = 0.
- The held-word register and the interrupt-pending flag are cleared.
- State becomes `BOOT`.

`BOOT`:
- `o_imem_addr = RESET_VECTOR_ADDR`.
- PC <= `i_imem_data`.
- `o_valid` <= 0.
- Next state: `RUN`.

`RUN`:
- `o_imem_addr = PC`.
- **Pending interrupt:** go to `INT` without consuming the word.
- **One-word instruction:**
  - `o_instr` <= data, `o_pc` <= PC, `o_pc_next` <= PC+1.
  - `o_valid` <= 1, `o_interrupt` <= 0.
  - PC <= PC+1.
- **Two-word instruction:**
  - Hold <= data, held PC <= PC, PC <= PC+1.
  - `o_valid` <= 0 (bubble).
  - Next state: `IMM`.

`IMM`:
- `o_imem_addr = PC`.
- `o_imm_value` <= data, `o_instr` <= hold, `o_pc` <= held PC, `o_pc_next` <= PC+1.
- `o_valid` <= 1.
- PC <= PC+1.
- Next state: `RUN`.

`INT`:
- `o_imem_addr = INT_VECTOR_ADDR`.
- `o_instr` <= `16'h0000` (NOP), `o_pc` <= PC, `o_pc_next` <= PC (return address).
- `o_valid` <= 1, `o_interrupt` <= 1.
- PC <= `i_imem_data`.
- The pending flag is cleared.
- Next state: `RUN`.

Interrupt capture:
- The pending flag is set whenever `i_interrupt` = 1.
- This happens in every state, including during stall and flush.
- Setting takes precedence over the clear in `INT` in the same cycle.

Flush:
- PC <= `i_branch_target`, `o_valid` <= 0, `o_interrupt` <= 0.
- Next state: `RUN` (this aborts `IMM`; the held word is discarded).
- The pending interrupt is retained.
- A flush in `BOOT` is ignored: the boot load completes.

Stall:
- Nothing changes except interrupt capture.
- `o_imem_addr` continues to reflect the current state.

Arithmetic and boundaries:
- PC arithmetic is 16-bit modulo; `16'hFFFF` + 1 = `16'h0000`.
- A two-word instruction at `16'hFFFF` takes its immediate from `16'h0000`.
- Interrupts are never taken between the two words of an instruction. An interrupt requested in `BOOT` or `IMM` is serviced on the first subsequent `RUN` cycle.

## Timing
- **Latency:** the memory word is fetched in cycle N and registered at the IF/ID outputs at the N+1 edge.
- **One-word instructions:** one valid instruction per cycle.
- **Two-word instructions:** two cycles; the first produces an `o_valid` = 0 bubble.
- **Boot:** after reset deassertion, one `BOOT` cycle; the first valid instruction appears two edges after reset is released.
- **Interrupt:** the `INT` slot costs one cycle; the handler's first instruction is fetched the following cycle.
- **Flush:** takes effect on the next edge; the target is fetched in the cycle after.
- **Reset:** asserted mid-`IMM` or mid-`INT`, it aborts immediately and returns to `BOOT`.

## Structure
- Shared package/header `cpu_pkg`:
  - `OPC_TWO_WORD` (`3'b110`);
  - fetch state encodings (`BOOT` = 0, `RUN` = 1, `IMM` = 2, `INT` = 3);
  - `NOP_INSTR` (`16'h0000`).
- Single module; no sub-module is needed. The PC, FSM and IF/ID output registers live in the same module.
- Instruction memory is external.

## Test plan
- **Reset and boot:** memory [0] = `16'h0010`, release reset, PC becomes 16 → `o_imem_addr` = `16'h0010` in the cycle after `BOOT`; `o_valid` = 0 until the first instruction registers.
- **One-word sequence:** one-word words at 16..18 → `o_valid` = 1 for three consecutive cycles with `o_pc` = 16, 17, 18.
- **Two-word instruction:** `16'hC000` at 20 followed by `16'hBEEF` → bubble, then `o_instr` = `16'hC000`, `o_imm_value` = `16'hBEEF`, `o_pc` = 20, `o_pc_next` = 22.
- **Interrupt during `IMM`:** pulse `i_interrupt` during `IMM` (instruction at 20), memory [1] = `16'h0100` → the two-word instruction completes, then `o_interrupt` = 1 with `o_pc_next` = 22, and the next fetch address is `16'h0100`.
- **Flush during `IMM` plus stall:**
  - `i_flush` with target `16'h0040` during `IMM` → `o_valid` = 0, next `o_imem_addr` = `16'h0040`, no stale immediate emitted.
  - 3-cycle `i_stall` → all outputs frozen.
- **PC wrap:** a one-word instruction at `16'hFFFF` → `o_pc_next` = `16'h0000`, next fetch at 0.
